// File: rtl/echo_chk_pkg.sv
// Shared types and helpers for the UART echo traffic checker.
// Holds the FSM state encoding, LFSR tap masks and the saturating counter step.
package echo_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Maximal-length Galois masks (right-shifting form)
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        return (width == 16) ? LFSR_TAPS_16 : {8'h00, LFSR_TAPS_8};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_value;
        max_value = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/echo_chk_fifo.sv
// Expected-data FIFO: pointers one bit wider than the address, flags derived
// purely from registered pointers, synchronous clear.
module echo_chk_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           wr_ptr_d;
    logic [AW:0]           rd_ptr_q;
    logic [AW:0]           rd_ptr_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    // The comparator needs the head in the same cycle as the echo arrives
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/echo_traffic_checker.sv
// UART echo traffic generator and checker: sends a counted pattern, checks echoes.
// Define ECHO_CHK_LFSR_EN to use a Galois LFSR pattern instead of an incrementing counter.
module echo_traffic_checker
    import echo_chk_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT_CYCLES  = 1_000_000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  num_bytes,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  extra_count,
    output logic [CNT_WIDTH-1:0]  first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got
);
    localparam int AW   = $clog2(MAX_OUTSTANDING);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]     ONE_ENTRY = (AW+1)'(1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  sent_q, sent_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic [CNT_WIDTH-1:0]  extra_q, extra_d;
    logic [CNT_WIDTH-1:0]  rx_idx_q, rx_idx_d;
    logic [CNT_WIDTH-1:0]  fidx_q, fidx_d;
    logic [DATA_WIDTH-1:0] fexp_q, fexp_d;
    logic [DATA_WIDTH-1:0] fgot_q, fgot_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_clr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [AW:0]           fifo_count;

    logic                  tx_valid_w;
    logic                  tx_fire;
    logic                  rx_fire;
    logic                  active;
    logic [DATA_WIDTH-1:0] pattern_adv;
    logic [DATA_WIDTH-1:0] seed_load;

`ifdef ECHO_CHK_LFSR_EN
    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
    assign pattern_adv = pattern_q[0] ? ((pattern_q >> 1) ^ TAPS) : (pattern_q >> 1);
    // An all-zero LFSR state would lock up
    assign seed_load   = (seed == '0) ? DATA_WIDTH'(1) : seed;
`else
    assign pattern_adv = pattern_q + DATA_WIDTH'(1);
    assign seed_load   = seed;
`endif

    echo_chk_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data (pattern_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign tx_valid_w = (state_q == ST_RUN) && (sent_q < num_q) && !fifo_full;
    assign tx_fire    = tx_valid_w && tx_ready;
    assign rx_fire    = rx_valid;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        sent_d    = sent_q;
        pattern_d = pattern_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        extra_d   = extra_q;
        rx_idx_d  = rx_idx_q;
        fidx_d    = fidx_q;
        fexp_d    = fexp_q;
        fgot_d    = fgot_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_clr  = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            fifo_clr = 1'b1;
        end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_d   = (num_bytes == '0) ? ST_DONE : ST_RUN;
            num_d     = num_bytes;
            sent_d    = '0;
            pattern_d = seed_load;
            wdog_d    = '0;
            timeout_d = 1'b0;
            err_d     = '0;
            extra_d   = '0;
            rx_idx_d  = '0;
            fidx_d    = '0;
            fexp_d    = '0;
            fgot_d    = '0;
            fifo_clr  = 1'b1;
        end else if (active) begin
            // Compare against the pre-push head: an echo racing a push into an empty FIFO is extra
            if (rx_fire) begin
                rx_idx_d = rx_idx_q + CNT_WIDTH'(1);
                if (fifo_empty) begin
                    extra_d = CNT_WIDTH'(sat_inc(32'(extra_q), CNT_WIDTH));
                end else begin
                    fifo_pop = 1'b1;
                    if (fifo_head != rx_data) begin
                        err_d = CNT_WIDTH'(sat_inc(32'(err_q), CNT_WIDTH));
                        if (err_q == '0) begin
                            fidx_d = rx_idx_q;
                            fexp_d = fifo_head;
                            fgot_d = rx_data;
                        end
                    end
                end
            end
            if (tx_fire) begin
                fifo_push = 1'b1;
                pattern_d = pattern_adv;
                sent_d    = sent_q + CNT_WIDTH'(1);
            end
            wdog_d = (tx_fire || rx_fire) ? '0 : wdog_q + WD_W'(1);

            if (!tx_fire && !rx_fire && wdog_q == WD_LAST) begin
                state_d   = ST_DONE;
                timeout_d = 1'b1;
            end else if (state_q == ST_RUN && sent_q == num_q) begin
                state_d = ST_DRAIN;
            end else if (state_q == ST_DRAIN &&
                         (fifo_empty || (fifo_count == ONE_ENTRY && fifo_pop))) begin
                state_d = ST_DONE;
            end
        end else if (state_q == ST_DONE && rx_fire) begin
            extra_d = CNT_WIDTH'(sat_inc(32'(extra_q), CNT_WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            sent_q    <= '0;
            pattern_q <= DATA_WIDTH'(1);
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            extra_q   <= '0;
            rx_idx_q  <= '0;
            fidx_q    <= '0;
            fexp_q    <= '0;
            fgot_q    <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            sent_q    <= sent_d;
            pattern_q <= pattern_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            extra_q   <= extra_d;
            rx_idx_q  <= rx_idx_d;
            fidx_q    <= fidx_d;
            fexp_q    <= fexp_d;
            fgot_q    <= fgot_d;
        end
    end

    assign tx_valid      = tx_valid_w;
    assign tx_data       = tx_valid_w ? pattern_q : '0;
    assign rx_ready      = 1'b1;
    assign busy          = active;
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_q == '0) && (extra_q == '0) && !timeout_q;
    assign timeout       = timeout_q;
    assign err_count     = err_q;
    assign extra_count   = extra_q;
    assign first_err_idx = fidx_q;
    assign first_err_exp = fexp_q;
    assign first_err_got = fgot_q;

endmodule

// File: tb/tb_echo_traffic_checker.sv
// Bench for echo_traffic_checker: loopback echo channel, directed scenarios and
// random runs, all checked every cycle against a queue-based behavioural model.
module tb_echo_traffic_checker;
    localparam int DW = 8;
    localparam int MO = 4;
    localparam int TO = 100;
    localparam int CW = 16;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_bytes = '0;
    logic [DW-1:0] seed = '0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] err_count, extra_count, first_err_idx;
    logic [DW-1:0] first_err_exp, first_err_got;

    echo_traffic_checker #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO),
        .TIMEOUT_CYCLES  (TO),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_bytes     (num_bytes),
        .seed          (seed),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .extra_count   (extra_count),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ph, m_num, m_sent, m_pat, m_idle, m_err, m_extra, m_rxidx;
    int m_fidx, m_fexp, m_fgot;
    bit m_to;
    int m_q[$];

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic bit exp_txv();
        return (m_ph == P_RUN) && (m_sent < m_num) && (m_q.size() < MO);
    endfunction

    task automatic model_clear_run();
        m_sent = 0; m_idle = 0; m_to = 0; m_err = 0; m_extra = 0; m_rxidx = 0;
        m_fidx = 0; m_fexp = 0; m_fgot = 0;
        m_q.delete();
    endtask

    task automatic model_reset();
        model_clear_run();
        m_ph = P_IDLE; m_num = 0; m_pat = 1;
    endtask

    task automatic model_step();
        bit txf, rxf;
        int old_sent, h;
        txf = exp_txv() && tx_ready;
        rxf = rx_valid;
        if (abort) begin
            m_ph = P_IDLE;
            m_q.delete();
        end else if (start && (m_ph == P_IDLE || m_ph == P_DONE)) begin
            model_clear_run();
            m_num = int'(num_bytes);
            m_pat = int'(seed);
            m_ph  = (num_bytes == 0) ? P_DONE : P_RUN;
        end else if (m_ph == P_RUN || m_ph == P_DRAIN) begin
            old_sent = m_sent;
            if (rxf) begin
                if (m_q.size() == 0) m_extra = sat(m_extra);
                else begin
                    h = m_q.pop_front();
                    if (h != int'(rx_data)) begin
                        if (m_err == 0) begin
                            m_fidx = m_rxidx; m_fexp = h; m_fgot = int'(rx_data);
                        end
                        m_err = sat(m_err);
                    end
                end
                m_rxidx++;
            end
            if (txf) begin
                m_q.push_back(m_pat);
                m_pat = (m_pat + 1) % 256;
                m_sent++;
            end
            m_idle = (txf || rxf) ? 0 : m_idle + 1;
            if (m_idle >= TO) begin
                m_ph = P_DONE; m_to = 1;
            end else if (m_ph == P_RUN && old_sent == m_num) m_ph = P_DRAIN;
            else if (m_ph == P_DRAIN && m_q.size() == 0) m_ph = P_DONE;
        end else if (m_ph == P_DONE && rxf) begin
            m_extra = sat(m_extra);
        end
    endtask

    task automatic compare();
        bit txv;
        txv = exp_txv();
        chk("tx_valid", tx_valid, txv);
        if (txv) chk("tx_data", tx_data, m_pat);
        chk("rx_ready", rx_ready, 1);
        chk("busy", busy, (m_ph == P_RUN || m_ph == P_DRAIN));
        chk("done", done, (m_ph == P_DONE));
        chk("pass", pass, (m_ph == P_DONE && m_err == 0 && m_extra == 0 && !m_to));
        chk("timeout", timeout, m_to);
        chk("err_count", err_count, m_err);
        chk("extra_count", extra_count, m_extra);
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("first_err_exp", first_err_exp, m_fexp);
        chk("first_err_got", first_err_got, m_fgot);
    endtask

    // Compare on the falling edge, then advance the model with the inputs the DUT sees next
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                compare();
            end else begin
                compare();
                model_step();
            end
        end
    end

    // ---------------- echo channel and stimulus ----------------
    typedef struct {
        logic [7:0] d;
        int         due;
    } echo_t;

    echo_t      echo_q[$];
    logic [7:0] sent_log[$];
    int cyc = 0, echo_delay = 3, echo_limit = 1 << 30, echo_stall = 0;
    int corrupt_idx = -1, echo_cnt = 0, last_xfer = 0, max_out = 0, done_cyc = 0;
    bit rand_ready = 0, stray_rx = 0;

    task automatic tick();
        echo_t e;
        int    out_now;
        @(negedge clk);
        if (tx_valid && tx_ready) begin
            sent_log.push_back(tx_data);
            if (sent_log.size() <= echo_limit) echo_q.push_back('{d: tx_data, due: cyc + echo_delay});
            last_xfer = cyc;
        end
        if (rx_valid) last_xfer = cyc;
        out_now = sent_log.size() - echo_cnt;
        if (out_now > max_out) max_out = out_now;
        @(posedge clk);
        cyc++;
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        rx_valid = 1'b0;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        if (stray_rx) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            stray_rx = 0;
        end else if (echo_stall > 0) begin
            echo_stall--;
        end else if (echo_q.size() > 0 && echo_q[0].due <= cyc) begin
            e = echo_q.pop_front();
            rx_data  = (echo_cnt == corrupt_idx) ? (e.d ^ 8'h01) : e.d;
            rx_valid = 1'b1;
            echo_cnt++;
        end
    endtask

    task automatic start_run(input int n, input logic [7:0] s);
        num_bytes = CW'(n);
        seed      = s;
        start     = 1'b1;
        sent_log.delete();
        echo_cnt  = 0;
        max_out   = 0;
        tick();
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        done_cyc = cyc;
        chk({name, "_done_within_budget"}, seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish (t=%0t)", $time);
        $fatal(1, "time limit");
    end

    initial begin
        int n, exp_err;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_rx_ready", rx_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err_count", err_count, 0);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        tick();

        // Plain loopback
        chk("t1_tx_valid_in_start_cycle", tx_valid, 0);
        start_run(10, 8'h7a);
        chk("t1_tx_valid_cycle_after_start", tx_valid, 1);
        wait_done(100, "t1");
        chk("t1_pass", pass, 1);
        chk("t1_err_count", err_count, 0);
        chk("t1_extra_count", extra_count, 0);
        chk("t1_sent_count", sent_log.size(), 10);
        for (int i = 0; i < 10; i++) chk("t1_sent_byte", sent_log[i], 8'h7a + i);

        // Fifth echo corrupted
        corrupt_idx = 4;
        start_run(10, 8'h7a);
        wait_done(100, "t2");
        corrupt_idx = -1;
        chk("t2_err_count", err_count, 1);
        chk("t2_first_err_idx", first_err_idx, 4);
        chk("t2_first_err_exp", first_err_exp, 8'h7e);
        chk("t2_first_err_got", first_err_got, 8'h7f);
        chk("t2_pass", pass, 0);
        chk("t2_model_pin_idx", m_fidx, 4);

        // Echoes stall, FIFO fills, then tx_ready held low for 20 cycles
        echo_stall = 40;
        start_run(12, 8'h10);
        repeat (10) tick();
        chk("t3_tx_valid_low_when_full", tx_valid, 0);
        chk("t3_outstanding_at_full", sent_log.size() - echo_cnt, 4);
        tx_ready = 1'b0;
        repeat (20) tick();
        tx_ready = 1'b1;
        wait_done(200, "t3");
        chk("t3_max_outstanding_le_4", (max_out <= 4), 1);
        chk("t3_pass", pass, 1);
        chk("t3_sent_count", sent_log.size(), 12);
        for (int i = 0; i < 12; i++) chk("t3_sent_byte", sent_log[i], 8'h10 + i);

        // Echo path cut after 3 bytes: done rises TO clock edges after the last transfer edge
        echo_limit = 3;
        start_run(8, 8'h40);
        wait_done(400, "t4");
        echo_limit = 1 << 30;
        chk("t4_edges_last_xfer_to_done", done_cyc - (last_xfer + 1), 100);
        chk("t4_timeout", timeout, 1);
        chk("t4_pass", pass, 0);

        // Zero-length run, then a stray symbol in DONE
        start_run(0, 8'h00);
        chk("t5_done_next_cycle", done, 1);
        chk("t5_pass_next_cycle", pass, 1);
        stray_rx = 1;
        tick();
        tick();
        chk("t5_extra_after_stray", extra_count, 1);
        chk("t5_pass_after_stray", pass, 0);

        // abort and start together: abort wins
        abort = 1'b1;
        start = 1'b1;
        num_bytes = 16'd5;
        tick();
        chk("t6_abort_beats_start_busy", busy, 0);
        chk("t6_abort_beats_start_done", done, 0);

        // abort mid-RUN
        start_run(10, 8'h30);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        chk("t7_tx_valid_after_abort", tx_valid, 0);
        chk("t7_busy_after_abort", busy, 0);
        repeat (8) tick();
        start_run(6, 8'h20);
        wait_done(100, "t7");
        chk("t7_pass_after_restart", pass, 1);

        // reset mid-RUN
        start_run(10, 8'h90);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t8_tx_valid_in_reset", tx_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        start_run(7, 8'hfc);
        wait_done(100, "t8");
        chk("t8_pass_after_restart", pass, 1);
        chk("t8_err_count", err_count, 0);

        // Random runs: throttled tx_ready, varied echo latency, occasional corruption
        rand_ready = 1;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 20);
            echo_delay = $urandom_range(1, 6);
            corrupt_idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            exp_err = (corrupt_idx >= 0) ? 1 : 0;
            start_run(n, 8'($urandom_range(0, 255)));
            wait_done(600, "rand");
            chk("rand_err_count", err_count, exp_err);
            chk("rand_pass", pass, (exp_err == 0));
            chk("rand_sent_count", sent_log.size(), n);
            repeat (2) tick();
        end
        rand_ready = 0;
        corrupt_idx = -1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
